tmds_gearbox_sequencer: RTL and testbench

TMDS_GEARBOX_SEQUENCER -- requirements
Module: tmds_gearbox_sequencer

---
 rtl/tmds_gearbox_sequencer.sv | 145 ++++++++++++++
 tb/tb_tmds_gearbox_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_gearbox_sequencer.sv
// rtl/tmds_gearbox_sequencer.sv - TMDS 10:5 gearbox with priming FIFO and underflow filler
module tmds_gearbox_sequencer #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         PRIME_LEVEL = 2,
    parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
    input  logic        clkLoad,
    input  logic        nReset,
    input  logic        enable,
    input  logic        symbolValid,
    output logic        symbolReady,
    input  logic [9:0]  symbol0,
    input  logic [9:0]  symbol1,
    input  logic [9:0]  symbol2,
    output logic        loadStrobe,
    output logic [4:0]  serialData0,
    output logic [4:0]  serialData1,
    output logic [4:0]  serialData2,
    output logic        underflow,
    output logic [15:0] underflowCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LEVEL);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   cur_q, cur_d;
    logic          ready_q, ready_d;
    logic          load_q, load_d;
    logic [14:0]   sd_q, sd_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   underflow_count_q, underflow_count_d;
    logic [29:0]   mem_q [FIFO_DEPTH];
    logic          push, pop;

    always_comb begin
        push              = symbolValid && ready_q;
        pop               = 1'b0;
        state_d           = state_q;
        phase_d           = phase_q;
        cur_d             = cur_q;
        load_d            = 1'b0;
        sd_d              = '0;
        underflow_d       = 1'b0;
        underflow_count_d = underflow_count_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (count_q >= PRIME_CNT) begin
                    state_d = ST_RUN;
                    phase_d = 1'b1;
                end
            end
            ST_RUN: begin
                phase_d = !phase_q;
                if (!phase_q) begin
                    load_d = 1'b1;
                    sd_d   = {cur_q[24:20], cur_q[14:10], cur_q[4:0]};
                end else begin
                    // load_q is low only on the first RUN cycle, when cur holds no symbol yet
                    if (load_q) begin
                        load_d = 1'b1;
                        sd_d   = {cur_q[29:25], cur_q[19:15], cur_q[9:5]};
                    end
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (count_q != '0) begin
                        pop   = 1'b1;
                        cur_d = mem_q[rd_ptr_q];
                    end else begin
                        cur_d       = {IDLE_SYMBOL, IDLE_SYMBOL, IDLE_SYMBOL};
                        underflow_d = 1'b1;
                        if (underflow_count_q != 16'hFFFF)
                            underflow_count_d = underflow_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (state_d == ST_IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            phase_d  = 1'b0;
            cur_d    = '0;
        end
        ready_d = (state_d != ST_IDLE) && (count_d != FULL_CNT);
    end

    always_ff @(posedge clkLoad) begin
        if (!nReset) begin
            state_q           <= ST_IDLE;
            phase_q           <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            cur_q             <= '0;
            ready_q           <= 1'b0;
            load_q            <= 1'b0;
            sd_q              <= '0;
            underflow_q       <= 1'b0;
            underflow_count_q <= '0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            cur_q             <= cur_d;
            ready_q           <= ready_d;
            load_q            <= load_d;
            sd_q              <= sd_d;
            underflow_q       <= underflow_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    always_ff @(posedge clkLoad) begin
        if (push) mem_q[wr_ptr_q] <= {symbol2, symbol1, symbol0};
    end

    assign symbolReady    = ready_q;
    assign loadStrobe     = load_q;
    assign serialData0    = sd_q[4:0];
    assign serialData1    = sd_q[9:5];
    assign serialData2    = sd_q[14:10];
    assign underflow      = underflow_q;
    assign underflowCount = underflow_count_q;

endmodule

// File: tb/tb_tmds_gearbox_sequencer.sv
// tb/tb_tmds_gearbox_sequencer.sv - directed bench for tmds_gearbox_sequencer
module tb_tmds_gearbox_sequencer;

    logic        clk = 1'b0;
    logic        n_reset, enable, symbol_valid;
    logic [9:0]  symbol0, symbol1, symbol2;
    logic        ready_a, load_a, uf_a, ready_b, load_b, uf_b;
    logic [4:0]  sd0_a, sd1_a, sd2_a, sd0_b, sd1_b, sd2_b;
    logic [15:0] ucnt_a, ucnt_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [9:0] PAT_A = 10'b1010101010;
    localparam logic [9:0] PAT_B = 10'b0000011111;
    localparam logic [9:0] PAT_C = 10'b0110011100;
    localparam logic [9:0] PAT_S = 10'b1110000111;

    always #5 clk = ~clk;

    tmds_gearbox_sequencer u_dut (
        .clkLoad(clk), .nReset(n_reset), .enable(enable), .symbolValid(symbol_valid),
        .symbolReady(ready_a), .symbol0(symbol0), .symbol1(symbol1), .symbol2(symbol2),
        .loadStrobe(load_a), .serialData0(sd0_a), .serialData1(sd1_a), .serialData2(sd2_a),
        .underflow(uf_a), .underflowCount(ucnt_a)
    );

    tmds_gearbox_sequencer #(.FIFO_DEPTH(4), .PRIME_LEVEL(4)) u_dut4 (
        .clkLoad(clk), .nReset(n_reset), .enable(enable), .symbolValid(symbol_valid),
        .symbolReady(ready_b), .symbol0(symbol0), .symbol1(symbol1), .symbol2(symbol2),
        .loadStrobe(load_b), .serialData0(sd0_b), .serialData1(sd1_b), .serialData2(sd2_b),
        .underflow(uf_b), .underflowCount(ucnt_b)
    );

    task automatic do_reset();
        n_reset = 1'b0; enable = 1'b0; symbol_valid = 1'b0;
        symbol0 = '0; symbol1 = '0; symbol2 = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_reset = 1'b0; enable = 1'b1; symbol_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ready_a, load_a, uf_a} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got %b want 000", {ready_a, load_a, uf_a}); end
        n_cmp++; if ({sd2_a, sd1_a, sd0_a} !== 15'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", {sd2_a, sd1_a, sd0_a}); end
        n_cmp++; if (ucnt_a !== 16'h0) begin n_bad++; $display("FAIL reset_ucnt got %h want 0", ucnt_a); end
        n_reset = 1'b1; enable = 1'b0; symbol_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ready_a, load_a, ready_b} !== 3'b000) begin n_bad++; $display("FAIL post_reset_idle got %b want 000", {ready_a, load_a, ready_b}); end
    endtask

    task automatic test_stream();
        do_reset();
        symbol0 = 10'h3FF; symbol1 = 10'h3FF; symbol2 = 10'h3FF;
        enable = 1'b1; symbol_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL stream_ready got %b want 1", ready_a); end
            end
            if (k == 5) begin
                n_cmp++; if (load_a !== 1'b0) begin n_bad++; $display("FAIL stream_first_run got %b want 0", load_a); end
            end
            if (k >= 6) begin
                n_cmp++;
                if ({load_a, uf_a, sd2_a, sd1_a, sd0_a, ucnt_a} !== {1'b1, 1'b0, 15'h7FFF, 16'h0}) begin
                    n_bad++; $display("FAIL stream_k%0d got load=%b uf=%b data=%h ucnt=%h want 1 0 7fff 0", k, load_a, uf_a, {sd2_a, sd1_a, sd0_a}, ucnt_a);
                end
            end
        end
        enable = 1'b0; symbol_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_underflow();
        logic [10:0] exp_t [5:17];
        exp_t = '{ {1'b0,1'b0,4'd0,5'b00000}, {1'b1,1'b0,4'd0,5'b01010}, {1'b1,1'b0,4'd0,5'b10101},
                   {1'b1,1'b0,4'd0,5'b11111}, {1'b1,1'b1,4'd1,5'b00000}, {1'b1,1'b0,4'd1,5'b10100},
                   {1'b1,1'b1,4'd2,5'b11010}, {1'b1,1'b0,4'd2,5'b10100}, {1'b1,1'b1,4'd3,5'b11010},
                   {1'b1,1'b0,4'd3,5'b10100}, {1'b1,1'b0,4'd3,5'b11010}, {1'b1,1'b0,4'd3,5'b11100},
                   {1'b1,1'b1,4'd4,5'b01100} };
        do_reset();
        enable = 1'b1; symbol_valid = 1'b1; symbol0 = PAT_A;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k >= 5) begin
                n_cmp++;
                if ({load_a, uf_a, ucnt_a[3:0], sd0_a} !== exp_t[k] || ucnt_a[15:4] !== 12'h0) begin
                    n_bad++; $display("FAIL underflow_k%0d got load=%b uf=%b ucnt=%h d0=%b want %b", k, load_a, uf_a, ucnt_a, sd0_a, exp_t[k]);
                end
            end
            if (k == 10) begin
                n_cmp++; if (sd1_a !== 5'b10100) begin n_bad++; $display("FAIL filler_ch1 got %b want 10100", sd1_a); end
            end
            if (k == 2) symbol0 = PAT_B;
            if (k == 3) symbol_valid = 1'b0;
            if (k == 12) begin symbol_valid = 1'b1; symbol0 = PAT_C; end
            if (k == 13) symbol_valid = 1'b0;
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_order();
        logic [9:0] v [5];
        logic [4:0] got [$];
        logic [4:0] want;
        int idx = 0;
        logic pushed = 1'b0;
        for (int i = 0; i < 5; i++) v[i] = {5'(i + 1), 5'(16 + i)};
        do_reset();
        symbol0 = v[0]; symbol_valid = 1'b1; enable = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (pushed) idx++;
            if (load_b) got.push_back(sd0_b);
            if (n == 4 || n == 7) begin
                n_cmp++; if (ready_b !== 1'b1) begin n_bad++; $display("FAIL full_ready_n%0d got %b want 1", n, ready_b); end
            end
            if (n == 5 || n == 6) begin
                n_cmp++; if (ready_b !== 1'b0) begin n_bad++; $display("FAIL full_blocked_n%0d got %b want 0", n, ready_b); end
            end
            if (idx >= 5) symbol_valid = 1'b0;
            else symbol0 = v[idx];
            pushed = symbol_valid && ready_b;
        end
        n_cmp++;
        if (got.size() < 10) begin
            n_bad++; $display("FAIL full_word_count got %0d want >=10", got.size());
        end else begin
            for (int j = 0; j < 10; j++) begin
                want = (j % 2 == 0) ? 5'(16 + j / 2) : 5'(j / 2 + 1);
                n_cmp++; if (got[j] !== want) begin n_bad++; $display("FAIL full_order_w%0d got %h want %h", j, got[j], want); end
            end
        end
        enable = 1'b0; symbol_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_disable();
        do_reset();
        symbol0 = PAT_S; symbol1 = PAT_S; symbol2 = PAT_S;
        enable = 1'b1; symbol_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 10) begin
                n_cmp++; if ({load_a, sd0_a} !== {1'b1, 5'b00111}) begin n_bad++; $display("FAIL disable_lo got %b %b want 1 00111", load_a, sd0_a); end
            end
            if (k == 11) begin
                n_cmp++; if ({load_a, sd0_a, ready_a} !== {1'b1, 5'b11100, 1'b0}) begin n_bad++; $display("FAIL disable_hi got %b %b %b want 1 11100 0", load_a, sd0_a, ready_a); end
            end
            if (k == 12) begin
                n_cmp++; if ({load_a, ready_a, sd2_a, sd1_a, sd0_a} !== 17'h0) begin n_bad++; $display("FAIL disable_idle got %b %b %h want 0 0 0", load_a, ready_a, {sd2_a, sd1_a, sd0_a}); end
            end
            if (k == 9) begin enable = 1'b0; symbol_valid = 1'b0; end
        end
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if ({load_a, uf_a} !== 2'b00) begin n_bad++; $display("FAIL flushed_k%0d got %b want 00", k, {load_a, uf_a}); end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        symbol0 = PAT_A; enable = 1'b1; symbol_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) symbol0 = PAT_B;
            if (k == 3) symbol_valid = 1'b0;
            if (k == 10) begin
                n_cmp++; if ({load_a, ucnt_a} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL mid_pre got %b %h want 1 0001", load_a, ucnt_a); end
                n_reset = 1'b0;
            end
            if (k == 11) begin
                n_cmp++;
                if ({ready_a, load_a, uf_a, sd2_a, sd1_a, sd0_a, ucnt_a} !== 34'h0) begin
                    n_bad++; $display("FAIL mid_reset got %b %b %b %h %h want all 0", ready_a, load_a, uf_a, {sd2_a, sd1_a, sd0_a}, ucnt_a);
                end
                n_reset = 1'b1; enable = 1'b0;
            end
            if (k == 12) begin
                n_cmp++; if ({ready_a, load_a, ucnt_a} !== 18'h0) begin n_bad++; $display("FAIL mid_after got %b %b %h want 0 0 0", ready_a, load_a, ucnt_a); end
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        symbol0 = PAT_A; enable = 1'b1; symbol_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) symbol0 = PAT_B;
            if (k == 3) symbol_valid = 1'b0;
            if (k == 9) begin
                n_cmp++; if ({uf_a, ucnt_a} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL sat_first got %b %h want 1 0001", uf_a, ucnt_a); end
                force u_dut.underflow_count_q = 16'hFFFD;
            end
            if (k == 10) release u_dut.underflow_count_q;
            if (k == 11) begin
                n_cmp++; if ({uf_a, ucnt_a} !== {1'b1, 16'hFFFE}) begin n_bad++; $display("FAIL sat_fffe got %b %h want 1 fffe", uf_a, ucnt_a); end
            end
            if (k == 12) begin
                n_cmp++; if (uf_a !== 1'b0) begin n_bad++; $display("FAIL sat_gap got %b want 0", uf_a); end
            end
            if (k == 13 || k == 15) begin
                n_cmp++; if ({uf_a, ucnt_a} !== {1'b1, 16'hFFFF}) begin n_bad++; $display("FAIL sat_k%0d got %b %h want 1 ffff", k, uf_a, ucnt_a); end
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_full_order();
        test_disable();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
